// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Package  : render_pkg
// Summary  : Shared renderer constants, coordinate widths, sink FSM states.
// Revision : 1.0
// ============================================================================
package render_pkg;

  localparam int SCREEN_X_DEF = 640;
  localparam int SCREEN_Y_DEF = 480;
  localparam int COLW         = 3;

  // Coordinate width used by every renderer so packed busses line up.
  function automatic int coord_w(input int extent);
    return $clog2(extent) + 1;
  endfunction

  localparam int PIX_XW = coord_w(SCREEN_X_DEF);
  localparam int PIX_YW = coord_w(SCREEN_Y_DEF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  typedef struct packed {
    logic [PIX_XW-1:0] x;
    logic [PIX_YW-1:0] y;
    logic [COLW-1:0]   col;
  } pixel_t;

endpackage
`default_nettype wire

// File: rtl/render_pixel_if.sv
`default_nettype none
// ============================================================================
// Interface : render_pixel_if
// Summary   : Packed multi-client pixel stream bus between renderers and sink.
// Revision  : 1.0
// ============================================================================
interface render_pixel_if
  import render_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int XW          = 11,
  parameter int YW          = 10
) ();

  logic [NUM_CLIENTS-1:0]      req;
  logic [NUM_CLIENTS-1:0]      valid;
  logic [NUM_CLIENTS-1:0]      last;
  logic [NUM_CLIENTS*XW-1:0]   x;
  logic [NUM_CLIENTS*YW-1:0]   y;
  logic [NUM_CLIENTS*COLW-1:0] col;
  logic [NUM_CLIENTS-1:0]      grant;
  logic [NUM_CLIENTS-1:0]      ready;
  logic [NUM_CLIENTS-1:0]      done;

  modport master (output req, valid, last, x, y, col, input grant, ready, done);
  modport slave  (input req, valid, last, x, y, col, output grant, ready, done);

endinterface
`default_nettype wire

// File: rtl/render_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : render_pixel_fifo
// Summary  : Synchronous power-of-two FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
module render_pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  wire logic                   clk,
  input  wire logic                   resetn,
  input  wire logic                   push,
  input  wire logic [WIDTH-1:0]       din,
  input  wire logic                   pop,
  output logic      [WIDTH-1:0]       dout,
  output logic                        full,
  output logic                        empty,
  output logic      [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == FULL_LVL);
  assign level  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/render_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : render_pixel_sink
// Summary  : Round-robin pixel arbiter + FIFO feeding the VGA plot port.
//            Define RENDER_CLIP_EN to drop off-screen pixels before the FIFO.
// Revision : 1.0
// ============================================================================
module render_pixel_sink
  import render_pkg::*;
#(
  parameter  int SCREEN_X    = 640,
  parameter  int SCREEN_Y    = 480,
  parameter  int NUM_CLIENTS = 3,
  parameter  int FIFO_DEPTH  = 8,
  localparam int XW          = coord_w(SCREEN_X),
  localparam int YW          = coord_w(SCREEN_Y),
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  render_pixel_if.slave      cli,
  input  wire logic          vga_stall,
  output logic [XW-1:0]      vga_x,
  output logic [YW-1:0]      vga_y,
  output logic [COLW-1:0]    vga_colour,
  output logic               vga_plot,
  output logic [LW-1:0]      fifo_level
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int PW = XW + YW + COLW;

  function automatic logic [IW-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                            input logic [IW-1:0]          ptr);
    logic [IW-1:0] pick;
    int            idx;
    pick = ptr;
    // Walk backwards so the requester closest to the pointer wins last.
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_CLIENTS;
      if (req[idx]) pick = IW'(idx);
    end
    return pick;
  endfunction

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  state_t                 r_state;
  logic [NUM_CLIENTS-1:0] r_grant;
  logic [NUM_CLIENTS-1:0] r_done;
  logic [IW-1:0]          r_gidx;
  logic [IW-1:0]          r_ptr;
  logic [IW-1:0]          w_pick;
  logic [XW-1:0]          w_sel_x;
  logic [YW-1:0]          w_sel_y;
  logic [COLW-1:0]        w_sel_col;
  logic                   w_accept;
  logic                   w_accept_last;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [PW-1:0]          w_dout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_pick        = rr_pick(cli.req, r_ptr);
  assign cli.grant     = r_grant;
  assign cli.done      = r_done;
  assign cli.ready     = (r_state == S_STREAM && !w_full) ? r_grant : '0;
  assign w_accept      = |(cli.valid & cli.ready);
  assign w_accept_last = |(cli.valid & cli.last & cli.ready);
  assign w_sel_x       = cli.x[r_gidx*XW +: XW];
  assign w_sel_y       = cli.y[r_gidx*YW +: YW];
  assign w_sel_col     = cli.col[r_gidx*COLW +: COLW];
  assign w_pop         = !w_empty && !vga_stall;

`ifdef RENDER_CLIP_EN
  assign w_push = w_accept && (w_sel_x < XW'(SCREEN_X)) && (w_sel_y < YW'(SCREEN_Y));
`else
  assign w_push = w_accept;
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|cli.req) r_state <= S_GRANT;
        end
        S_GRANT: begin
          if (|cli.req) begin
            r_gidx  <= w_pick;
            r_grant <= NUM_CLIENTS'(1) << w_pick;
            r_state <= S_STREAM;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_STREAM: begin
          if (w_accept_last) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_ptr   <= (r_gidx == IW'(NUM_CLIENTS - 1)) ? '0 : r_gidx + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  render_pixel_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (w_rst_n),
    .push   (w_push),
    .din    ({w_sel_x, w_sel_y, w_sel_col}),
    .pop    (w_pop),
    .dout   (w_dout),
    .full   (w_full),
    .empty  (w_empty),
    .level  (fifo_level)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= w_pop;
      if (w_pop) begin
        vga_x      <= w_dout[PW-1 -: XW];
        vga_y      <= w_dout[COLW +: YW];
        vga_colour <= w_dout[COLW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_render_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_render_pixel_sink
// Summary  : Self-checking bench: random bursts vs. round-robin/FIFO model.
// Revision : 1.0
// ============================================================================
module tb_render_pixel_sink;
  import render_pkg::*;

  localparam int NC = 3;
  localparam int XW = PIX_XW;
  localparam int YW = PIX_YW;
  localparam int PW = XW + YW + COLW;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            vga_stall = 1'b0;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [COLW-1:0] vga_colour;
  logic            vga_plot;
  logic [3:0]      fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int model_ptr = 0;

  logic [PW-1:0] plot_q[$];
  int            plot_cyc_q[$];
  logic [PW-1:0] exp_q[$];

  render_pixel_if #(.NUM_CLIENTS(NC), .XW(XW), .YW(YW)) cli_if ();

  render_pixel_sink #(
    .SCREEN_X    (640),
    .SCREEN_Y    (480),
    .NUM_CLIENTS (NC),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cli        (cli_if),
    .vga_stall  (vga_stall),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      plot_q.push_back({vga_x, vga_y, vga_colour});
      plot_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_push(input pixel_t p);
`ifdef RENDER_CLIP_EN
    return (int'(p.x) < 640) && (int'(p.y) < 480);
`else
    return 1'b1;
`endif
  endfunction

  function automatic pixel_t make_pix(input int mode, input int c, input int i);
    pixel_t p;
    case (mode)
      1: begin p.x = XW'(320 + i); p.y = YW'(240); p.col = 3'b111; end
      2: begin p.x = XW'(638 + i); p.y = YW'(100 + c); p.col = COLW'(i); end
      default: begin
        p.x   = XW'($urandom_range(0, 639));
        p.y   = YW'($urandom_range(0, 479));
        p.col = COLW'($urandom_range(0, 7));
      end
    endcase
    return p;
  endfunction

  task automatic run_bursts(input string name, input logic [2:0] mask,
                            input int l0, input int l1, input int l2, input int mode,
                            input bit rvalid, input bit rstall, input int stall_hold,
                            input int hold_level, input bit chk_lat);
    logic [PW-1:0] pix [NC][64];
    int            len [NC];
    int            sent [NC];
    int            order[$];
    logic [2:0]    pend;
    int            p, c2, oi, g, budget, first_acc;
    bit            pend_done, found;
    len = '{l0, l1, l2};
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 64; i++) pix[c][i] = make_pix(mode, c, i);
    // Expected grant order: repeatedly take the first pending requester at/after the pointer.
    pend = mask;
    p = model_ptr;
    while (pend != 3'b000) begin
      found = 1'b0;
      for (int k = 0; k < NC; k++) begin
        c2 = (p + k) % NC;
        if (!found && pend[c2]) begin
          order.push_back(c2);
          pend[c2] = 1'b0;
          p = (c2 + 1) % NC;
          found = 1'b1;
        end
      end
    end
    sent = '{0, 0, 0};
    oi = 0; pend_done = 1'b0; first_acc = -1; budget = 0;
    cli_if.req = mask;
    while (oi < order.size()) begin
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) begin
        if (cli_if.req[c] && cli_if.grant[c] && sent[c] < len[c]) begin
          cli_if.valid[c] = rvalid ? ($urandom_range(0, 3) != 0) : 1'b1;
          {cli_if.x[c*XW +: XW], cli_if.y[c*YW +: YW], cli_if.col[c*COLW +: COLW]} = pix[c][sent[c]];
          cli_if.last[c] = (sent[c] == len[c] - 1);
        end else if (cli_if.req[c]) begin
          cli_if.valid[c] = 1'($urandom);
          cli_if.last[c]  = 1'($urandom);
          cli_if.x[c*XW +: XW]       = XW'($urandom);
          cli_if.y[c*YW +: YW]       = YW'($urandom);
          cli_if.col[c*COLW +: COLW] = COLW'($urandom);
        end else begin
          cli_if.valid[c] = 1'b0;
          cli_if.last[c]  = 1'b0;
        end
      end
      vga_stall = (budget < stall_hold) ? 1'b1 : (rstall ? ($urandom_range(0, 2) == 0) : 1'b0);
      @(negedge clk);
      g = order[oi];
      check({name, "_done"}, cli_if.done, pend_done ? (1 << g) : 0);
      check({name, "_ready_owner"}, cli_if.ready & ~cli_if.grant, 0);
      if (pend_done) begin
        check({name, "_grant_drop"}, cli_if.grant, 0);
        cli_if.req[g] = 1'b0; cli_if.valid[g] = 1'b0; cli_if.last[g] = 1'b0;
        oi++;
        pend_done = 1'b0;
      end else begin
        if (cli_if.grant != '0) check({name, "_grant"}, cli_if.grant, 1 << g);
        if (cli_if.valid[g] && cli_if.ready[g]) begin
          if (first_acc < 0) first_acc = cyc;
          if (model_push(pix[g][sent[g]])) exp_q.push_back(pix[g][sent[g]]);
          sent[g]++;
          if (sent[g] == len[g]) pend_done = 1'b1;
        end
      end
      if (stall_hold > 0 && budget == stall_hold - 1) begin
        check({name, "_hold_level"}, fifo_level, hold_level);
        check({name, "_hold_noplot"}, plot_q.size(), 0);
        check({name, "_hold_ready"}, cli_if.ready, 0);
      end
      budget++;
      if (budget > 3000) begin
        check({name, "_timeout"}, oi, order.size());
        break;
      end
    end
    model_ptr = p;
    cli_if.req = '0; cli_if.valid = '0; cli_if.last = '0;
    vga_stall = 1'b0;
    budget = 0;
    while (fifo_level != 0 && budget < 200) begin @(negedge clk); budget++; end
    repeat (3) @(negedge clk);
    check({name, "_drained"}, fifo_level, 0);
    check({name, "_plot_count"}, plot_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < plot_q.size(); i++)
      check({name, "_plot_pix"}, plot_q[i], exp_q[i]);
    if (chk_lat) begin
      if (plot_cyc_q.size() > 0) check({name, "_latency"}, plot_cyc_q[0] - first_acc, 2);
      else check({name, "_latency_noplot"}, 0, 1);
    end
    plot_q.delete(); plot_cyc_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    cli_if.req = '0; cli_if.valid = '0; cli_if.last = '0;
    cli_if.x = '0; cli_if.y = '0; cli_if.col = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", cli_if.grant, 0);
    check("rst_ready", cli_if.ready, 0);
    check("rst_done",  cli_if.done, 0);
    check("rst_plot",  vga_plot, 0);
    check("rst_level", fifo_level, 0);
    check("rst_xyc",   {vga_x, vga_y, vga_colour}, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    run_bursts("rr3",    3'b111, 4, 4, 4, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_bursts("rrwrap", 3'b101, 3, 0, 3, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_bursts("seq16",  3'b001, 16, 0, 0, 1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_bursts("stall",  3'b001, 12, 0, 0, 0, 1'b0, 1'b0, 20, 8, 1'b0);
    for (int r = 0; r < 6; r++)
      run_bursts("rand", 3'($urandom_range(1, 7)), $urandom_range(1, 10),
                 $urandom_range(1, 10), $urandom_range(1, 10), 0, 1'b1, 1'b1, 0, 0, 1'b0);
    run_bursts("clip",   3'b001, 4, 0, 0, 2, 1'b0, 1'b0, 0, 0, 1'b0);
    run_bursts("single", 3'b010, 0, 1, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Mid-burst reset on client 2 with pixels parked in the FIFO.
    vga_stall = 1'b1;
    cli_if.req = 3'b100;
    k = 0;
    while (cli_if.grant[2] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    check("mrst_grant", cli_if.grant, 3'b100);
    repeat (4) begin
      @(posedge clk); #1;
      cli_if.valid[2] = 1'b1; cli_if.last[2] = 1'b0;
      cli_if.x[2*XW +: XW] = XW'($urandom_range(0, 639));
    end
    @(posedge clk); #1;
    check("mrst_pre_level", fifo_level, 4);
    #1 resetn = 1'b0;
    #1;
    check("mrst_grant0", cli_if.grant, 0);
    check("mrst_ready0", cli_if.ready, 0);
    check("mrst_done0",  cli_if.done, 0);
    check("mrst_plot0",  vga_plot, 0);
    check("mrst_level0", fifo_level, 0);
    check("mrst_xyc0",   {vga_x, vga_y, vga_colour}, 0);
    cli_if.req = '0; cli_if.valid = '0; cli_if.last = '0;
    vga_stall = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_noplot", plot_q.size(), 0);
    plot_q.delete(); plot_cyc_q.delete();
    model_ptr = 0;
    run_bursts("postrst", 3'b110, 0, 2, 2, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
